// File: rtl/pipeline_pkg.sv
// Shared types and widths for the br32 pipeline stages.
package pipeline_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SHL, ALU_SHR, ALU_SAR, ALU_SLT, ALU_SLTU,
    ALU_MUL, ALU_MULH, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_ALWAYS
  } br_cond_t;

  typedef enum logic [1:0] {
    DIV_IDLE, DIV_RUN, DIV_DONE
  } div_state_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  nextpc;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [XLEN-1:0]  mem_data;
    alu_op_t          alu_op;
    br_cond_t         br_cond;
    logic [XLEN-1:0]  target;
    logic [REG_W-1:0] rd;
    logic             w_rd;
    logic             link;
    logic             bubble;
  } id_out_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  nextpc;
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  mem_data;
    logic [REG_W-1:0] rd;
    logic             w_rd;
    logic             link;
    logic             bubble;
  } ex_out_t;

  // Magnitude of x, treating it as two's complement only when sgn is set.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
  endfunction

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/stage_ex_div.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, fixed latency.
module stage_ex_div
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic            want_rem,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state, state_n;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  a_q, b_q, dvs, quo, rem;
  logic             sgn_q, rem_sel_q;

  logic [XLEN:0]    part, diff;
  logic             ge;
  logic [XLEN-1:0]  quo_n, rem_n, q_fix, r_fix, res_n;
  logic             q_neg, r_neg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_n;
  end

  // Next-state logic and status flags.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      DIV_IDLE: if (start) state_n = DIV_RUN;
      DIV_RUN: begin
        busy = 1'b1;
        if (count == LAST) state_n = DIV_DONE;
      end
      DIV_DONE: begin
        done    = 1'b1;
        state_n = DIV_IDLE;
      end
      default: state_n = DIV_IDLE;
    endcase
  end

  // One restoring step; borrow out of the subtract means the divisor did not fit.
  always_comb begin
    part  = {rem, quo[XLEN-1]};
    diff  = part - {1'b0, dvs};
    ge    = ~diff[XLEN];
    rem_n = ge ? diff[XLEN-1:0] : part[XLEN-1:0];
    quo_n = {quo[XLEN-2:0], ge};
    q_neg = sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg = sgn_q & a_q[XLEN-1];
    q_fix = q_neg ? XLEN'(-quo_n) : quo_n;
    r_fix = r_neg ? XLEN'(-rem_n) : rem_n;
    if (b_q == '0) begin
      q_fix = ALL_ONES;
      r_fix = a_q;
    end else if (sgn_q && (a_q == INT_MIN) && (b_q == ALL_ONES)) begin
      q_fix = INT_MIN;
      r_fix = '0;
    end
    res_n = rem_sel_q ? r_fix : q_fix;
  end

  // Operand load, iteration and final result capture on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (state == DIV_IDLE && start) begin
      a_q       <= a;
      b_q       <= b;
      sgn_q     <= signed_op;
      rem_sel_q <= want_rem;
      quo       <= abs_val(a, signed_op);
      dvs       <= abs_val(b, signed_op);
      rem       <= '0;
      count     <= '0;
    end else if (state == DIV_RUN) begin
      quo   <= quo_n;
      rem   <= rem_n;
      count <= CNT_W'(count + 1'b1);
      if (count == LAST) result <= res_n;
    end
  end

endmodule

// File: rtl/stage_ex.sv
// Execute stage: input register, ALU/multiplier, branch resolve, divider control.
module stage_ex
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  id_out_t         ID,
  output ex_out_t         out,
  output logic            stall,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target
);

  id_out_t          id_q;
  logic [XLEN-1:0]  alu_res;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic             is_div, div_start, div_busy, div_done, div_signed, div_rem;
  logic [XLEN-1:0]  div_result;
  logic             eq, lt, ltu, cond;

  // Input register; reset only needs to turn the held instruction into a bubble.
  always_ff @(posedge clk) begin
    if (!stall) id_q <= ID;
    if (rst)    id_q.bubble <= 1'b1;
  end

  // Divider handshake; a new divide is accepted only when the divider is idle.
  always_comb begin
    is_div     = is_div_op(id_q.alu_op);
    div_signed = (id_q.alu_op == ALU_DIV) || (id_q.alu_op == ALU_REM);
    div_rem    = (id_q.alu_op == ALU_REM) || (id_q.alu_op == ALU_REMU);
    div_start  = is_div && !id_q.bubble && !div_busy && !div_done;
    stall      = div_busy || div_start;
  end

  stage_ex_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (div_signed),
    .want_rem  (div_rem),
    .a         (id_q.op1),
    .b         (id_q.op2),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  // Single 64-bit multiplier; operand extension selects signed or unsigned high half.
  always_comb begin
    mul_a = {{XLEN{(id_q.alu_op == ALU_MULH) & id_q.op1[XLEN-1]}}, id_q.op1};
    mul_b = {{XLEN{(id_q.alu_op == ALU_MULH) & id_q.op2[XLEN-1]}}, id_q.op2};
    prod  = mul_a * mul_b;
  end

  // ALU result.
  always_comb begin
    alu_res = '0;
    unique case (id_q.alu_op)
      ALU_ADD:   alu_res = XLEN'(id_q.op1 + id_q.op2);
      ALU_SUB:   alu_res = XLEN'(id_q.op1 - id_q.op2);
      ALU_AND:   alu_res = id_q.op1 & id_q.op2;
      ALU_OR:    alu_res = id_q.op1 | id_q.op2;
      ALU_XOR:   alu_res = id_q.op1 ^ id_q.op2;
      ALU_SHL:   alu_res = id_q.op1 << id_q.op2[4:0];
      ALU_SHR:   alu_res = id_q.op1 >> id_q.op2[4:0];
      ALU_SAR:   alu_res = XLEN'($signed(id_q.op1) >>> id_q.op2[4:0]);
      ALU_SLT:   alu_res = XLEN'($signed(id_q.op1) < $signed(id_q.op2));
      ALU_SLTU:  alu_res = XLEN'(id_q.op1 < id_q.op2);
      ALU_MUL:   alu_res = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHU: alu_res = prod[2*XLEN-1:XLEN];
      default:   alu_res = '0;
    endcase
  end

  // Branch condition and redirect.
  always_comb begin
    eq  = id_q.op1 == id_q.op2;
    lt  = $signed(id_q.op1) < $signed(id_q.op2);
    ltu = id_q.op1 < id_q.op2;
    cond = 1'b0;
    unique case (id_q.br_cond)
      BR_NONE:   cond = 1'b0;
      BR_EQ:     cond = eq;
      BR_NE:     cond = !eq;
      BR_LT:     cond = lt;
      BR_GE:     cond = !lt;
      BR_LTU:    cond = ltu;
      BR_GEU:    cond = !ltu;
      BR_ALWAYS: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
    br_taken  = cond && !id_q.bubble;
    br_target = id_q.target;
  end

  // Output bundle to stage_mem; held divides appear as bubbles until DONE.
  always_comb begin
    out.pc       = id_q.pc;
    out.nextpc   = id_q.nextpc;
    out.alu_res  = div_done ? div_result : alu_res;
    out.mem_data = id_q.mem_data;
    out.rd       = id_q.rd;
    out.w_rd     = id_q.w_rd;
    out.link     = id_q.link;
    out.bubble   = id_q.bubble || stall;
  end

endmodule

// File: tb/tb_stage_ex.sv
// Directed testbench for stage_ex.
module tb_stage_ex;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  id_out_t     id_in;
  ex_out_t     ex_out;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;

  int n_tests = 0;
  int n_fail  = 0;

  stage_ex dut (
    .clk       (clk),
    .rst       (rst),
    .ID        (id_in),
    .out       (ex_out),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input alu_op_t op, input br_cond_t c,
                        input logic [31:0] a, input logic [31:0] b, input logic bub);
    id_in.pc       = 32'h0000_0100;
    id_in.nextpc   = 32'h0000_0104;
    id_in.op1      = a;
    id_in.op2      = b;
    id_in.mem_data = 32'h0000_CAFE;
    id_in.alu_op   = op;
    id_in.br_cond  = c;
    id_in.target   = 32'h0000_0400;
    id_in.rd       = 5'd5;
    id_in.w_rd     = 1'b1;
    id_in.link     = 1'b0;
    id_in.bubble   = bub;
  endtask

  // Issue a divide, count stall cycles (bounded) and check the DONE-cycle result.
  task automatic run_div(input string tag, input alu_op_t op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    set_id(op, BR_NONE, a, b, 1'b0);
    step();
    set_id(ALU_ADD, BR_NONE, 32'h0, 32'h0, 1'b1);
    n = 0;
    while (stall && n < 40) begin
      n++;
      check({tag, "_bubble_in_stall"}, 32'(ex_out.bubble), 32'd1);
      step();
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd33);
    check({tag, "_done_stall"}, 32'(stall), 32'd0);
    check({tag, "_done_bubble"}, 32'(ex_out.bubble), 32'd0);
    check({tag, "_result"}, ex_out.alu_res, exp);
  endtask

  initial begin
    logic leak;
    rst = 1'b1;
    set_id(ALU_ADD, BR_NONE, 32'h0, 32'h0, 1'b1);
    step();
    step();
    rst = 1'b0;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bubble", 32'(ex_out.bubble), 32'd1);
    check("rst_br_taken", 32'(br_taken), 32'd0);

    // Back-to-back single-cycle ops.
    set_id(ALU_ADD, BR_NONE, 32'd7, 32'hFFFF_FFFF, 1'b0);
    step();
    check("add_res", ex_out.alu_res, 32'd6);
    check("add_bubble", 32'(ex_out.bubble), 32'd0);
    check("add_rd", 32'(ex_out.rd), 32'd5);
    check("add_stall", 32'(stall), 32'd0);
    set_id(ALU_SAR, BR_NONE, 32'h8000_0000, 32'd4, 1'b0);
    step();
    check("sar_res", ex_out.alu_res, 32'hF800_0000);
    check("sar_stall", 32'(stall), 32'd0);
    set_id(ALU_MULH, BR_NONE, 32'hFFFF_FFFE, 32'd3, 1'b0);
    step();
    check("mulh_res", ex_out.alu_res, 32'hFFFF_FFFF);
    set_id(ALU_MULHU, BR_NONE, 32'hFFFF_FFFE, 32'd3, 1'b0);
    step();
    check("mulhu_res", ex_out.alu_res, 32'h0000_0002);
    set_id(ALU_MUL, BR_NONE, 32'hFFFF_FFFE, 32'd3, 1'b0);
    step();
    check("mul_res", ex_out.alu_res, 32'hFFFF_FFFA);
    set_id(ALU_SLT, BR_NONE, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    check("slt_res", ex_out.alu_res, 32'd1);
    set_id(ALU_SLTU, BR_NONE, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    check("sltu_res", ex_out.alu_res, 32'd0);

    // Divides, including the special cases.
    run_div("div_m7_2",  ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("rem_m7_2",  ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14);
    run_div("divu_by0",  ALU_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    run_div("div_ovf",   ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("remu_by0",  ALU_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234);
    step();
    check("post_div_bubble", 32'(ex_out.bubble), 32'd1);

    // Taken branch redirects for exactly one cycle.
    set_id(ALU_ADD, BR_LT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    check("blt_taken", 32'(br_taken), 32'd1);
    check("blt_target", br_target, 32'h0000_0400);
    set_id(ALU_ADD, BR_NONE, 32'h0, 32'h0, 1'b1);
    step();
    check("blt_one_cycle", 32'(br_taken), 32'd0);
    set_id(ALU_ADD, BR_LT, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    check("blt_bubble_no_redirect", 32'(br_taken), 32'd0);
    set_id(ALU_ADD, BR_GEU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    check("bgeu_taken", 32'(br_taken), 32'd1);
    set_id(ALU_DIV, BR_NONE, 32'd9, 32'd3, 1'b1);
    step();
    check("div_bubble_no_stall", 32'(stall), 32'd0);

    // Reset in the middle of a divide aborts it cleanly.
    set_id(ALU_DIV, BR_NONE, 32'd100, 32'd7, 1'b0);
    step();
    set_id(ALU_ADD, BR_NONE, 32'd2, 32'd3, 1'b0);
    for (int i = 0; i < 11; i++) step();
    check("mid_div_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_bubble", 32'(ex_out.bubble), 32'd1);
    step();
    check("after_abort_add", ex_out.alu_res, 32'd5);
    check("after_abort_add_bubble", 32'(ex_out.bubble), 32'd0);
    set_id(ALU_ADD, BR_NONE, 32'h0, 32'h0, 1'b1);
    leak = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!ex_out.bubble || stall) leak = 1'b1;
    end
    check("no_stale_done", 32'(leak), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_ex.md
# stage_ex

Execute stage of the five-stage br32 pipeline, between the decode stage (`id_out_t`) and `stage_mem` (`ex_out_t`). It registers the decoded instruction and computes the ALU/multiply result. It resolves conditional branches and redirects fetch. It runs an iterative radix-2 divider, stalling upstream stages while a divide is in flight.

## Interface
- No parameters; widths are fixed by `pipeline_pkg` (XLEN 32).
- `clk`  in  1  pipeline clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ID`  in  `id_out_t`  decoded instruction fields:
  - `pc`, `nextpc`: addresses.
  - `op1`, `op2`: operands; `op2` is already immediate-muxed.
  - `mem_data`: store data.
  - `alu_op`: `alu_op_t`.
  - `br_cond`: `br_cond_t`.
  - `target`: branch target.
  - `rd`, `w_rd`, `link`, `bubble`.
- `out`  out  `ex_out_t`  `pc`, `nextpc`, `alu_res`, `mem_data`, `rd`, `w_rd`, `link`, `bubble`; registered into `stage_mem`.
- `stall`  out  1  upstream stages must hold their registers this cycle.
- `br_taken`  out  1  redirect fetch; upstream stages flush younger instructions.
- `br_target`  out  32  redirect address, valid when `br_taken`.

## Operation
- Input register:
  - On each edge with `stall`=0: capture every `ID` field.
  - `bubble <= ID.bubble || rst`.
  - With `stall`=1: hold all captured fields.
- ALU, combinational from the captured fields:
  - ADD, SUB, AND, OR, XOR.
  - SHL, SHR, SAR: shift amount `op2[4:0]`.
  - SLT, SLTU: result 1 or 0, zero-extended.
  - MUL: low 32 bits.
  - MULH: signed×signed, high 32 bits.
  - MULHU: unsigned×unsigned, high 32 bits.
- Divide ops DIV, DIVU, REM, REMU go to sub-module `stage_ex_div`.
- Divide FSM, states IDLE / RUN / DONE:
  - IDLE → RUN: captured op is a divide and `bubble`=0. Operands load; `count` set to 0.
  - RUN: one quotient bit per cycle; `count` 0..31. After `count`=31, go to DONE.
  - DONE → IDLE unconditionally. The result is presented this cycle.
  - `rst` forces IDLE from any state.
- `stall` = (state==RUN) || (state==IDLE && divide op && !bubble).
- Divide special cases, same fixed latency:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = dividend.
  - Signed 0x80000000 / -1: quotient 0x80000000; remainder 0.
  - Signed remainder takes the sign of the dividend.
- `out` fields:
  - `out.bubble` = `bubble` || `stall`.
  - `out.alu_res` = divider result in DONE, otherwise the ALU result.
  - All other `out` fields pass through from the captured fields.
- Branch conditions compare `op1` with `op2`: NONE, EQ, NE, LT, GE, LTU, GEU, ALWAYS.
  - `br_taken` = condition true && !`bubble`.
  - `br_target` = captured `target`.
  - A branch is never a divide, so `br_taken` and `stall` are mutually exclusive.

## Timing
- After a reset edge:
  - state IDLE; `bubble`=1; `stall`=0; `br_taken`=0.
  - `out.bubble`=1; `out.w_rd` undefined but gated by bubble downstream.
- Reset mid-divide: the next edge aborts the divide. Nothing is written, and nothing stale appears in a later DONE.
- Non-divide ops: 1-cycle occupancy; result visible on `out` the cycle after capture.
- Divide, edges counted from the capture edge:
  - `stall`=1 for 33 cycles (IDLE, then RUN×32).
  - DONE occupies cycle 34, with `stall`=0 and a valid result.
  - The next instruction is captured at the end of cycle 34.
  - `stage_mem` sees exactly one non-bubble copy of the instruction.
- `br_taken` is combinational from the captured registers and asserted for exactly one cycle per taken branch.
- A bubble carrying a divide or branch encoding causes no stall and no redirect.

## Structure
- `pipeline_pkg` holds `id_out_t`, `ex_out_t`, `alu_op_t`, `br_cond_t` and XLEN.
- `stage_ex_div` is the only sub-module:
  - Ports: `clk`, `rst`, `start`, `signed_op`, `want_rem`, `a`, `b`, `busy`, `done`, `result`.
  - It owns `count`, the partial remainder and the quotient shift registers.
  - It applies sign correction and special cases in the DONE cycle.
- `stage_ex` owns the input register, ALU, branch compare and output mux.

## Test plan
- ADD with op1=7, op2=0xFFFFFFFF, then SAR with op1=0x80000000, op2=4 → `alu_res`=6, then 0xF8000000, on consecutive cycles; `stall` stays 0.
- MULH with 0xFFFFFFFE × 3 → 0xFFFFFFFF; MULHU with the same operands → 0x00000002.
- DIV with −7/2 → `stall` high for 33 cycles and `out.bubble`=1 throughout. DONE cycle shows 0xFFFFFFFD. The following REM gives −1 (0xFFFFFFFF).
- DIVU with divisor 0 → 0xFFFFFFFF after full latency. DIV 0x80000000/−1 → 0x80000000. REMU x/0 → x.
- BLT with op1=−1, op2=1 → `br_taken`=1, `br_target`=`target` for one cycle. The same instruction with `ID.bubble`=1 → no redirect.
- `rst` pulsed at RUN count 10 → next cycle IDLE, `stall`=0, `out.bubble`=1. A following ADD completes normally with no divide result leaking.
